// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width,
// operation codes and controller states.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_EQ  = 4'd8,
        OP_GT  = 4'd9,
        OP_LT  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: computes one operation on two operands and
// reports carry/borrow and an illegal-opcode flag.
module alu_core #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] out,
    output logic              carry,
    output logic              err
);
    import alu_pkg::*;

    logic [DATA_W:0] wide;

    // Decode the opcode; unused codes yield a zero result with the error flag set
    always_comb begin
        out   = '0;
        carry = 1'b0;
        err   = 1'b0;
        wide  = '0;
        case (sel)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                out   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                out   = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_SHL: out = {a[DATA_W-2:0], 1'b0};
            OP_SHR: out = {1'b0, a[DATA_W-1:1]};
            OP_EQ:  out[0] = (a == b);
            OP_GT:  out[0] = (a > b);
            OP_LT:  out[0] = (a < b);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: round-robin arbitration,
// operand capture, one-cycle execute and a held response until consumed.
module alu_arbiter #(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_sel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);
    import alu_pkg::*;

    state_e            state;
    state_e            state_next;
    logic              last_id;
    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [3:0]        cap_sel;
    logic              cap_id;
    logic [DATA_W-1:0] core_out;
    logic              core_carry;
    logic              core_err;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .a     (cap_a),
        .b     (cap_b),
        .sel   (cap_sel),
        .out   (core_out),
        .carry (core_carry),
        .err   (core_err)
    );

    // Pick the winner: a lone requester wins, a tie goes to whoever was not served last; ready is gated by reset
    always_comb begin
        grant_id  = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end else if (req_valid == 2'b11) begin
            grant_id = ~last_id;
        end
        accept = rst_n && (state == IDLE) && (req_valid != 2'b00);
        if (accept) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    // Next-state logic: execute takes exactly one cycle, response waits for the consumer
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the granted request, then register the ALU result so it stays stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id   <= 1'b1;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_sel   <= '0;
            cap_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            if (accept) begin
                last_id <= grant_id;
                cap_id  <= grant_id;
                cap_a   <= grant_id ? req1_a : req0_a;
                cap_b   <= grant_id ? req1_b : req0_b;
                cap_sel <= grant_id ? req1_sel : req0_sel;
            end
            if (state == EXEC) begin
                rsp_out   <= core_out;
                rsp_zero  <= (core_out == '0);
                rsp_carry <= core_carry;
                rsp_err   <= core_err;
                rsp_id    <= cap_id;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized transactions compared against an arithmetic reference model.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [3:0] req0_sel;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [3:0] req1_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_out;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       rsp_err;
    logic       busy;

    int checks;
    int errors;
    int last_served;

    alu_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_sel  (req0_sel),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_sel  (req1_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                                 input logic [3:0] s0, input logic [7:0] a1, input logic [7:0] b1,
                                 input logic [3:0] s1);
        req_valid = v;
        req0_a    = a0;
        req0_b    = b0;
        req0_sel  = s0;
        req1_a    = a1;
        req1_b    = b1;
        req1_sel  = s1;
    endtask

    // Reference ALU written directly from the opcode table with integer arithmetic
    task automatic refModel(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            output int out, output int carry, output int err);
        int ai;
        int bi;
        ai    = int'(a);
        bi    = int'(b);
        out   = 0;
        carry = 0;
        err   = 0;
        case (int'(sel))
            0: begin out = (ai + bi) % 256; carry = (ai + bi > 255) ? 1 : 0; end
            1: begin out = (ai - bi + 256) % 256; carry = (ai < bi) ? 1 : 0; end
            2: out = ai & bi;
            3: out = ai | bi;
            4: out = ai ^ bi;
            5: out = 255 - ai;
            6: out = (ai * 2) % 256;
            7: out = ai / 2;
            8: out = (ai == bi) ? 1 : 0;
            9: out = (ai > bi) ? 1 : 0;
            10: out = (ai < bi) ? 1 : 0;
            default: begin out = 0; err = 1; end
        endcase
    endtask

    task automatic checkResponse(input string tag, input int exp_id, input int exp_out,
                                 input int exp_carry, input int exp_err);
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_out"},   32'(rsp_out), exp_out);
        checkOutput({tag, "_carry"}, 32'(rsp_carry), exp_carry);
        checkOutput({tag, "_err"},   32'(rsp_err), exp_err);
        checkOutput({tag, "_zero"},  32'(rsp_zero), (exp_out == 0) ? 32'd1 : 32'd0);
        checkOutput({tag, "_id"},    32'(rsp_id), exp_id);
    endtask

    // One full transaction: grant, execute cycle, response held for 'hold' extra cycles
    task automatic runTxn(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [3:0] s0, input logic [7:0] a1, input logic [7:0] b1,
                          input logic [3:0] s1, input int hold, input bit keep_valid);
        int exp_id;
        int exp_out;
        int exp_carry;
        int exp_err;
        int waited;
        @(negedge clk);
        rsp_ready = 1'b0;
        applyStimulus(v, a0, b0, s0, a1, b1, s1);
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        waited = 0;
        while (req_ready == 2'b00 && waited < 4) begin
            @(negedge clk);
            #1;
            waited++;
        end
        exp_id = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : 1 - last_served;
        checkOutput("grant", 32'(req_ready), (exp_id == 0) ? 32'd1 : 32'd2);
        last_served = exp_id;
        if (exp_id == 0) refModel(a0, b0, s0, exp_out, exp_carry, exp_err);
        else             refModel(a1, b1, s1, exp_out, exp_carry, exp_err);

        @(negedge clk);
        if (!keep_valid) begin
            applyStimulus(2'b00, 8'($urandom), 8'($urandom), 4'($urandom),
                          8'($urandom), 8'($urandom), 4'($urandom));
        end
        #1;
        checkOutput("exec_valid", 32'(rsp_valid), 32'd0);
        checkOutput("exec_busy",  32'(busy), 32'd1);
        checkOutput("exec_ready", 32'(req_ready), 32'd0);

        @(negedge clk);
        rsp_ready = (hold == 0);
        #1;
        checkResponse("rsp", exp_id, exp_out, exp_carry, exp_err);
        checkOutput("rsp_ready_blocked", 32'(req_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            rsp_ready = (i == hold - 1);
            #1;
            checkResponse("hold", exp_id, exp_out, exp_carry, exp_err);
            checkOutput("hold_ready", 32'(req_ready), 32'd0);
            checkOutput("hold_busy",  32'(busy), 32'd1);
        end
    endtask

    initial begin
        logic [1:0] rv;
        checks      = 0;
        errors      = 0;
        last_served = 1;
        rsp_ready   = 1'b0;
        rst_n       = 1'b1;
        applyStimulus(2'b00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0);

        // Reset state, with requests present to show ready stays low
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_out",   32'(rsp_out), 32'd0);
        checkOutput("rst_zero",  32'(rsp_zero), 32'd0);
        checkOutput("rst_carry", 32'(rsp_carry), 32'd0);
        checkOutput("rst_err",   32'(rsp_err), 32'd0);
        checkOutput("rst_id",    32'(rsp_id), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready_held", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // Lone requester 0 ADD with carry out
        runTxn(2'b01, 8'hF0, 8'h20, 4'd0, 8'h00, 8'h00, 4'd0, 0, 1'b0);
        // SUB equal operands, then SUB with borrow
        runTxn(2'b01, 8'h05, 8'h05, 4'd1, 8'h00, 8'h00, 4'd0, 0, 1'b0);
        runTxn(2'b10, 8'h00, 8'h00, 4'd0, 8'h03, 8'h05, 4'd1, 0, 1'b0);
        // Illegal opcode and unsigned greater-than
        runTxn(2'b10, 8'h00, 8'h00, 4'd0, 8'h12, 8'h34, 4'hC, 0, 1'b0);
        runTxn(2'b01, 8'h80, 8'h7F, 4'd9, 8'h00, 8'h00, 4'd0, 0, 1'b0);
        // Consumer stalls five cycles; a competing request keeps waiting
        runTxn(2'b11, 8'hA5, 8'h0F, 4'd2, 8'h3C, 8'hC3, 4'd4, 5, 1'b1);
        runTxn(2'b11, 8'hA5, 8'h0F, 4'd2, 8'h3C, 8'hC3, 4'd4, 0, 1'b0);

        // Reset during EXEC: outputs clear at once and the operation is lost
        @(negedge clk);
        rsp_ready = 1'b1;
        applyStimulus(2'b01, 8'h7F, 8'h01, 4'd0, 8'h00, 8'h00, 4'd0);
        #1;
        checkOutput("pre_rst_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        applyStimulus(2'b11, 8'h11, 8'h22, 4'd3, 8'h33, 8'h44, 4'd3);
        #1;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy",  32'(busy), 32'd0);
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        checkOutput("mid_rst_out",   32'(rsp_out), 32'd0);
        checkOutput("mid_rst_flags", 32'({rsp_zero, rsp_carry, rsp_err, rsp_id}), 32'd0);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        last_served = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Both requesters always valid: grants alternate starting at requester 0
        for (int i = 0; i < 4; i++) begin
            runTxn(2'b11, 8'(10 + i), 8'(3 * i), 4'd0, 8'(200 + i), 8'(i), 4'd1, 0, 1'b1);
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            rv = 2'($urandom_range(1, 3));
            runTxn(rv, 8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                   4'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        checkOutput("final_idle", 32'(busy), 32'd0);
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
